// File: rtl/spi_slave_word.sv
// SPI slave endpoint: synchronises sck/ssel_/mosi into clk, shifts
// WIDTH-bit words in both directions, and exposes valid/ready RX and TX
// handshakes with overrun/underrun pulses. Supports all four SPI modes.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   sck, ssel_, mosi      raw SPI master pins (asynchronous)
//   miso, miso_oe         slave data out and its pad enable
//   rx_data/valid/ready   received word handshake, rx_overrun pulse
//   tx_data/valid/ready   transmit word handshake, tx_underrun pulse
//   frame_start/end       pulses on synchronised select/deselect
module spi_slave_word #(
    parameter int               WIDTH   = 8,
    parameter bit               CPOL    = 1'b0,
    parameter bit               CPHA    = 1'b0,
    parameter logic [WIDTH-1:0] TX_IDLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             ssel_,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [2:0]       sck_s;
    logic [2:0]       ssel_s;
    logic [1:0]       mosi_s;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] tx_buf;
    logic             tx_full;
    logic             miso_r;

    logic             selected;
    logic             sck_rise;
    logic             sck_fall;
    logic             lead;
    logic             trail;
    logic             sample;
    logic             shift;
    logic             start;
    logic             stop;
    logic             last;
    logic             done;
    logic             load;
    logic [WIDTH-1:0] rx_word;

    assign selected = ~ssel_s[1];
    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign sck_fall = ~sck_s[1] & sck_s[2];
    assign lead     = CPOL ? sck_fall : sck_rise;
    assign trail    = CPOL ? sck_rise : sck_fall;
    assign sample   = selected & (CPHA ? trail : lead);
    // With CPHA=0 the trailing edge right after a word's last sample must
    // not shift, otherwise the freshly loaded MSB would be lost.
    assign shift    = selected & (CPHA ? lead : trail)
                    & (CPHA || (bit_cnt != '0));
    assign start    = ssel_s[2] & ~ssel_s[1];
    assign stop     = ~ssel_s[2] & ssel_s[1];
    assign last     = (bit_cnt == CW'(WIDTH - 1));
    assign done     = sample & last;
    assign load     = start | done;
    assign rx_word  = {rx_shift[WIDTH-2:0], mosi_s[1]};

    assign miso     = CPHA ? miso_r : tx_shift[WIDTH-1];
    assign miso_oe  = selected;
    assign tx_ready = ~tx_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s       <= {3{CPOL}};
            ssel_s      <= 3'b111;
            mosi_s      <= '0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            miso_r      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            sck_s       <= {sck_s[1:0], sck};
            ssel_s      <= {ssel_s[1:0], ssel_};
            mosi_s      <= {mosi_s[0], mosi};
            frame_start <= start;
            frame_end   <= stop;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;

            if (!selected) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                miso_r   <= 1'b0;
            end else begin
                if (sample) begin
                    rx_shift <= rx_word;
                    bit_cnt  <= last ? '0 : bit_cnt + CW'(1);
                end
                if (load) begin
                    tx_shift    <= tx_full ? tx_buf : TX_IDLE;
                    tx_underrun <= ~tx_full;
                end else if (shift) begin
                    miso_r   <= tx_shift[WIDTH-1];
                    tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                end
            end

            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            // A write landing on a load point fills the buffer for the
            // following word; it never bypasses into the shifter.
            if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end else if (load && tx_full) begin
                tx_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_word.sv
// Self-checking bench for spi_slave_word: mode 0 (8-bit, TX_IDLE=0x5A),
// mode 1 and mode 3 (16-bit) instances driven by a bit-banged master.
module tb_spi_slave_word;

    localparam int HALF = 6;

    int total = 0;
    int bad   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sck_lo = 1'b0;
    logic sck_hi = 1'b1;
    logic mosi   = 1'b0;
    logic [2:0] ssel_n = 3'b111;
    logic [2:0] rxr    = 3'b000;
    logic [2:0] txv    = 3'b000;
    logic [7:0]  txd0 = '0;
    logic [15:0] txd1 = '0;
    logic [15:0] txd2 = '0;

    wire [2:0]  miso_w, oe_w, rv_w, ovr_w, txr_w, udr_w, fs_w, fe_w;
    wire [7:0]  rxd0;
    wire [15:0] rxd1, rxd2;

    int ovr[3];
    int udr[3];
    int fs[3];
    int fe[3];
    int hs[3];
    logic [15:0] hsd [3][8];

    always #5 clk = ~clk;

    spi_slave_word #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0),
                     .TX_IDLE(8'h5A)) u0 (
        .clk(clk), .rst_n(rst_n), .sck(sck_lo), .ssel_(ssel_n[0]),
        .mosi(mosi), .miso(miso_w[0]), .miso_oe(oe_w[0]),
        .rx_data(rxd0), .rx_valid(rv_w[0]), .rx_ready(rxr[0]),
        .rx_overrun(ovr_w[0]), .tx_data(txd0), .tx_valid(txv[0]),
        .tx_ready(txr_w[0]), .tx_underrun(udr_w[0]),
        .frame_start(fs_w[0]), .frame_end(fe_w[0]));

    spi_slave_word #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .sck(sck_lo), .ssel_(ssel_n[1]),
        .mosi(mosi), .miso(miso_w[1]), .miso_oe(oe_w[1]),
        .rx_data(rxd1), .rx_valid(rv_w[1]), .rx_ready(rxr[1]),
        .rx_overrun(ovr_w[1]), .tx_data(txd1), .tx_valid(txv[1]),
        .tx_ready(txr_w[1]), .tx_underrun(udr_w[1]),
        .frame_start(fs_w[1]), .frame_end(fe_w[1]));

    spi_slave_word #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .sck(sck_hi), .ssel_(ssel_n[2]),
        .mosi(mosi), .miso(miso_w[2]), .miso_oe(oe_w[2]),
        .rx_data(rxd2), .rx_valid(rv_w[2]), .rx_ready(rxr[2]),
        .rx_overrun(ovr_w[2]), .tx_data(txd2), .tx_valid(txv[2]),
        .tx_ready(txr_w[2]), .tx_underrun(udr_w[2]),
        .frame_start(fs_w[2]), .frame_end(fe_w[2]));

    function automatic logic [15:0] rxd_of(input int d);
        if (d == 0) return {8'h00, rxd0};
        if (d == 1) return rxd1;
        return rxd2;
    endfunction

    // Pulse and handshake monitors
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ovr_w[i]) ovr[i]++;
            if (udr_w[i]) udr[i]++;
            if (fs_w[i]) fs[i]++;
            if (fe_w[i]) fe[i]++;
            if (rv_w[i] && rxr[i]) begin
                if (hs[i] < 8) hsd[i][hs[i]] = rxd_of(i);
                hs[i]++;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sck(input int d, input logic v);
        if (d == 2) sck_hi = v;
        else sck_lo = v;
    endtask

    task automatic sel(input int d);
        ssel_n[d] = 1'b0;
        wait_clk(6);
    endtask

    task automatic desel(input int d);
        wait_clk(6);
        ssel_n[d] = 1'b1;
        wait_clk(6);
    endtask

    task automatic write_tx(input int d, input logic [15:0] v);
        if (d == 0) txd0 = v[7:0];
        else if (d == 1) txd1 = v;
        else txd2 = v;
        txv[d] = 1'b1;
        wait_clk(1);
        txv[d] = 1'b0;
    endtask

    task automatic pulse_ready(input int d);
        rxr[d] = 1'b1;
        wait_clk(1);
        rxr[d] = 1'b0;
    endtask

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        while (!txr_w[d] && n < 3000) begin
            wait_clk(1);
            n++;
        end
        total++;
        if (!txr_w[d]) begin
            bad++;
            $display("FAIL tx_ready_wait dev=%0d timed out", d);
        end
    endtask

    // Master shifts nbits of the width-bit word w_out, MSB first;
    // w_in collects miso at the master's sampling edge.
    task automatic xfer(input int d, input int width, input int nbits,
                        input logic [15:0] w_out,
                        output logic [15:0] w_in);
        logic c;
        logic h;
        c = (d == 2);
        h = (d != 0);
        w_in = '0;
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = w_out[width-1-i];
            if (!h) begin
                mosi = b;
                wait_clk(HALF);
                set_sck(d, ~c);
                w_in = {w_in[14:0], miso_w[d]};
                wait_clk(HALF);
                set_sck(d, c);
            end else begin
                set_sck(d, ~c);
                mosi = b;
                wait_clk(HALF);
                set_sck(d, c);
                w_in = {w_in[14:0], miso_w[d]};
                wait_clk(HALF);
            end
        end
    endtask

    task automatic test_reset();
        wait_clk(4);
        total++;
        if (miso_w[0] !== 1'b0 || oe_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_miso got=%b%b want=00",
                     miso_w[0], oe_w[0]);
        end
        total++;
        if (rxd0 !== 8'h00 || rv_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_rx got=%h/%b want=00/0", rxd0, rv_w[0]);
        end
        total++;
        if (txr_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_tx_ready got=%b want=1", txr_w[0]);
        end
        total++;
        if ({ovr_w[0], udr_w[0], fs_w[0], fe_w[0]} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000",
                     {ovr_w[0], udr_w[0], fs_w[0], fe_w[0]});
        end
        rst_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_mode0();
        logic [15:0] r;
        int u, o, s, e;
        write_tx(0, 16'h00A5);
        total++;
        if (txr_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL m0_tx_full got=%b want=0", txr_w[0]);
        end
        u = udr[0]; o = ovr[0]; s = fs[0]; e = fe[0];
        ssel_n[0] = 1'b0;
        wait_clk(5);
        total++;
        if (txr_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL m0_tx_ready_after_start got=%b want=1",
                     txr_w[0]);
        end
        wait_clk(1);
        xfer(0, 8, 8, 16'h003C, r);
        desel(0);
        total++;
        if (r[7:0] !== 8'hA5) begin
            bad++;
            $display("FAIL m0_miso got=%h want=a5", r[7:0]);
        end
        total++;
        if (rxd0 !== 8'h3C || rv_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL m0_rx got=%h/%b want=3c/1", rxd0, rv_w[0]);
        end
        total++;
        if (fs[0] - s != 1 || fe[0] - e != 1) begin
            bad++;
            $display("FAIL m0_frame_pulses got=%0d/%0d want=1/1",
                     fs[0] - s, fe[0] - e);
        end
        // the completion load finds the buffer empty
        total++;
        if (udr[0] - u != 1 || ovr[0] - o != 0) begin
            bad++;
            $display("FAIL m0_flags got=udr%0d ovr%0d want=udr1 ovr0",
                     udr[0] - u, ovr[0] - o);
        end
        pulse_ready(0);
        total++;
        if (rv_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL m0_rx_handshake got=%b want=0", rv_w[0]);
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic [15:0] r1, r2;
        int u, o, h;
        rxr[d] = 1'b1;
        write_tx(d, 16'h1234);
        u = udr[d]; o = ovr[d]; h = hs[d];
        fork
            begin
                sel(d);
                xfer(d, 16, 16, 16'hCAFE, r1);
                xfer(d, 16, 16, 16'h0F0F, r2);
                desel(d);
            end
            begin
                wait_ready(d);
                write_tx(d, 16'hBEEF);
                wait_ready(d);
                write_tx(d, 16'h0000);
            end
        join
        rxr[d] = 1'b0;
        total++;
        if (r1 !== 16'h1234 || r2 !== 16'hBEEF) begin
            bad++;
            $display("FAIL b2b_miso dev=%0d got=%h,%h want=1234,beef",
                     d, r1, r2);
        end
        total++;
        if (hs[d] - h != 2) begin
            bad++;
            $display("FAIL b2b_handshakes dev=%0d got=%0d want=2",
                     d, hs[d] - h);
        end
        total++;
        if (hsd[d][h] !== 16'hCAFE || hsd[d][h+1] !== 16'h0F0F) begin
            bad++;
            $display("FAIL b2b_rx dev=%0d got=%h,%h want=cafe,0f0f",
                     d, hsd[d][h], hsd[d][h+1]);
        end
        total++;
        if (udr[d] - u != 0 || ovr[d] - o != 0) begin
            bad++;
            $display("FAIL b2b_flags dev=%0d got=udr%0d ovr%0d want=0,0",
                     d, udr[d] - u, ovr[d] - o);
        end
    endtask

    task automatic test_underrun();
        logic [15:0] r1, r2;
        int u, h;
        rxr[0] = 1'b1;
        u = udr[0]; h = hs[0];
        sel(0);
        total++;
        if (udr[0] - u != 1) begin
            bad++;
            $display("FAIL udr_at_start got=%0d want=1", udr[0] - u);
        end
        xfer(0, 8, 8, 16'h0011, r1);
        xfer(0, 8, 8, 16'h0022, r2);
        desel(0);
        rxr[0] = 1'b0;
        total++;
        if (r1[7:0] !== 8'h5A || r2[7:0] !== 8'h5A) begin
            bad++;
            $display("FAIL udr_miso got=%h,%h want=5a,5a",
                     r1[7:0], r2[7:0]);
        end
        // frame start plus one per completed word
        total++;
        if (udr[0] - u != 3) begin
            bad++;
            $display("FAIL udr_count got=%0d want=3", udr[0] - u);
        end
        total++;
        if (hs[0] - h != 2) begin
            bad++;
            $display("FAIL udr_handshakes got=%0d want=2", hs[0] - h);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] r;
        int o;
        o = ovr[0];
        sel(0);
        xfer(0, 8, 8, 16'h0001, r);
        xfer(0, 8, 8, 16'h0002, r);
        xfer(0, 8, 8, 16'h0003, r);
        desel(0);
        total++;
        if (rxd0 !== 8'h01 || rv_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL ovr_hold got=%h/%b want=01/1", rxd0, rv_w[0]);
        end
        total++;
        if (ovr[0] - o != 2) begin
            bad++;
            $display("FAIL ovr_count got=%0d want=2", ovr[0] - o);
        end
        pulse_ready(0);
        total++;
        if (rv_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL ovr_release got=%b want=0", rv_w[0]);
        end
    endtask

    task automatic test_abort();
        logic [15:0] r;
        int u;
        sel(0);
        write_tx(0, 16'h00C3);
        u = udr[0];
        xfer(0, 8, 5, 16'h00FF, r);
        desel(0);
        total++;
        if (rv_w[0] !== 1'b0 || rxd0 !== 8'h01) begin
            bad++;
            $display("FAIL abort_rx got=%h/%b want=01/0", rxd0, rv_w[0]);
        end
        total++;
        if (txr_w[0] !== 1'b0 || udr[0] - u != 0) begin
            bad++;
            $display("FAIL abort_tx got=rdy%b udr%0d want=rdy0 udr0",
                     txr_w[0], udr[0] - u);
        end
        sel(0);
        xfer(0, 8, 8, 16'h0081, r);
        desel(0);
        total++;
        if (rxd0 !== 8'h81 || rv_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL abort_next_rx got=%h/%b want=81/1",
                     rxd0, rv_w[0]);
        end
        total++;
        if (r[7:0] !== 8'hC3) begin
            bad++;
            $display("FAIL abort_next_miso got=%h want=c3", r[7:0]);
        end
        pulse_ready(0);
    endtask

    task automatic test_async_reset();
        logic [15:0] r;
        sel(0);
        xfer(0, 8, 8, 16'h0042, r);
        desel(0);
        write_tx(0, 16'h0099);
        sel(0);
        xfer(0, 8, 3, 16'h00FF, r);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (rv_w[0] !== 1'b0 || rxd0 !== 8'h00) begin
            bad++;
            $display("FAIL areset_rx got=%h/%b want=00/0", rxd0, rv_w[0]);
        end
        total++;
        if (txr_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL areset_tx_ready got=%b want=1", txr_w[0]);
        end
        total++;
        if (oe_w[0] !== 1'b0 || miso_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL areset_miso got=%b%b want=00",
                     oe_w[0], miso_w[0]);
        end
        ssel_n[0] = 1'b1;
        sck_lo = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        sel(0);
        xfer(0, 8, 8, 16'h00E7, r);
        desel(0);
        total++;
        if (rxd0 !== 8'hE7 || rv_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL areset_frame_rx got=%h/%b want=e7/1",
                     rxd0, rv_w[0]);
        end
        total++;
        if (r[7:0] !== 8'h5A) begin
            bad++;
            $display("FAIL areset_frame_miso got=%h want=5a", r[7:0]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0();
        test_back_to_back(2);
        test_back_to_back(1);
        test_underrun();
        test_overrun();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
